// File: rtl/video_mnist_cnn_detection_bbox_if.sv
// AXI4-Stream class-hit map bus between the CNN detection core and the bbox sink.
interface video_mnist_cnn_detection_bbox_if #(
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned CLASS_NUM   = 10
) ();
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    logic [CLASS_NUM-1:0]   tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (
        output tuser,
        output tlast,
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tuser,
        input  tlast,
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/video_mnist_cnn_detection_bbox.sv
// Per-class hit count and bounding box accumulation over one detection-map frame.
// Results are latched and strobed one cycle after the closing beat has been folded.
module video_mnist_cnn_detection_bbox #(
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned CLASS_NUM   = 10,
    parameter int unsigned X_WIDTH     = 10,
    parameter int unsigned Y_WIDTH     = 9,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [Y_WIDTH-1:0]               param_y_num,
    input  logic [COUNT_WIDTH-1:0]           param_min_count,
    video_mnist_cnn_detection_bbox_if.slave  s_axi4s,
    output logic                             m_result_valid,
    output logic [CLASS_NUM-1:0]             m_result_detect,
    output logic [CLASS_NUM*X_WIDTH-1:0]     m_result_min_x,
    output logic [CLASS_NUM*X_WIDTH-1:0]     m_result_max_x,
    output logic [CLASS_NUM*Y_WIDTH-1:0]     m_result_min_y,
    output logic [CLASS_NUM*Y_WIDTH-1:0]     m_result_max_y,
    output logic [CLASS_NUM*COUNT_WIDTH-1:0] m_result_count,
    output logic                             m_frame_error
);

    typedef enum logic [0:0] {StWaitSof, StActive} state_t;

    state_t                 r_state, w_state_d;
    logic                   r_tready;
    logic [X_WIDTH-1:0]     r_x, w_x_d, w_cx;
    logic [Y_WIDTH-1:0]     r_y, w_y_d, w_cy;
    logic [Y_WIDTH-1:0]     r_y_num, w_y_num_d;
    logic                   r_close, w_close_d;
    logic                   r_frame_error, w_error_d;

    logic [COUNT_WIDTH-1:0] r_cnt   [CLASS_NUM];
    logic [COUNT_WIDTH-1:0] w_cnt_d [CLASS_NUM];
    logic [X_WIDTH-1:0]     r_min_x [CLASS_NUM];
    logic [X_WIDTH-1:0]     w_min_x_d [CLASS_NUM];
    logic [X_WIDTH-1:0]     r_max_x [CLASS_NUM];
    logic [X_WIDTH-1:0]     w_max_x_d [CLASS_NUM];
    logic [Y_WIDTH-1:0]     r_min_y [CLASS_NUM];
    logic [Y_WIDTH-1:0]     w_min_y_d [CLASS_NUM];
    logic [Y_WIDTH-1:0]     r_max_y [CLASS_NUM];
    logic [Y_WIDTH-1:0]     w_max_y_d [CLASS_NUM];

    logic                             r_res_valid;
    logic [CLASS_NUM-1:0]             r_res_detect;
    logic [CLASS_NUM*X_WIDTH-1:0]     r_res_min_x, r_res_max_x;
    logic [CLASS_NUM*Y_WIDTH-1:0]     r_res_min_y, r_res_max_y;
    logic [CLASS_NUM*COUNT_WIDTH-1:0] r_res_count;

    logic w_beat;
    logic w_sof;

    assign w_beat         = s_axi4s.tvalid && r_tready;
    assign w_sof          = s_axi4s.tuser[0];
    assign s_axi4s.tready = r_tready;

    // Next-state: coordinate walk, frame open/close and per-class accumulation of one beat.
    always_comb begin
        w_state_d = r_state;
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_cx      = r_x;
        w_cy      = r_y;
        w_y_num_d = r_y_num;
        w_close_d = 1'b0;
        w_error_d = 1'b0;
        w_cnt_d   = r_cnt;
        w_min_x_d = r_min_x;
        w_max_x_d = r_max_x;
        w_min_y_d = r_min_y;
        w_max_y_d = r_max_y;

        if (w_beat && (r_state == StActive || w_sof)) begin
            w_state_d = StActive;
            if (w_sof) begin
                // SOF always restarts: the beat becomes pixel (0,0) of a fresh frame.
                w_cx      = '0;
                w_cy      = '0;
                w_y_num_d = param_y_num;
                w_error_d = (r_state == StActive) && ((r_x != '0) || (r_y != '0));
                for (int c = 0; c < CLASS_NUM; c++) begin
                    w_cnt_d[c]   = '0;
                    w_min_x_d[c] = '1;
                    w_max_x_d[c] = '0;
                    w_min_y_d[c] = '1;
                    w_max_y_d[c] = '0;
                end
            end

            for (int c = 0; c < CLASS_NUM; c++) begin
                if (s_axi4s.tdata[c]) begin
                    if (w_cx < w_min_x_d[c]) w_min_x_d[c] = w_cx;
                    if (w_cx > w_max_x_d[c]) w_max_x_d[c] = w_cx;
                    if (w_cy < w_min_y_d[c]) w_min_y_d[c] = w_cy;
                    if (w_cy > w_max_y_d[c]) w_max_y_d[c] = w_cy;
                    if (w_cnt_d[c] != '1) w_cnt_d[c] = w_cnt_d[c] + COUNT_WIDTH'(1);
                end
            end

            if (s_axi4s.tlast) begin
                w_x_d = '0;
                if (w_cy == w_y_num_d - Y_WIDTH'(1)) begin
                    w_close_d = 1'b1;
                    w_state_d = StWaitSof;
                    w_y_d     = '0;
                end else begin
                    w_y_d = (w_cy == '1) ? w_cy : w_cy + Y_WIDTH'(1);
                end
            end else begin
                w_x_d = (w_cx == '1) ? w_cx : w_cx + X_WIDTH'(1);
                w_y_d = w_cy;
            end
        end
    end

    // State, coordinates and accumulators.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= StWaitSof;
            r_tready      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_y_num       <= '0;
            r_close       <= 1'b0;
            r_frame_error <= 1'b0;
            for (int c = 0; c < CLASS_NUM; c++) begin
                r_cnt[c]   <= '0;
                r_min_x[c] <= '1;
                r_max_x[c] <= '0;
                r_min_y[c] <= '1;
                r_max_y[c] <= '0;
            end
        end else begin
            r_state       <= w_state_d;
            r_tready      <= 1'b1;
            r_x           <= w_x_d;
            r_y           <= w_y_d;
            r_y_num       <= w_y_num_d;
            r_close       <= w_close_d;
            r_frame_error <= w_error_d;
            r_cnt         <= w_cnt_d;
            r_min_x       <= w_min_x_d;
            r_max_x       <= w_max_x_d;
            r_min_y       <= w_min_y_d;
            r_max_y       <= w_max_y_d;
        end
    end

    // Result latch: reads the accumulators of the just-closed frame before any reload lands.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_res_valid  <= 1'b0;
            r_res_detect <= '0;
            r_res_min_x  <= '0;
            r_res_max_x  <= '0;
            r_res_min_y  <= '0;
            r_res_max_y  <= '0;
            r_res_count  <= '0;
        end else begin
            r_res_valid <= r_close;
            if (r_close) begin
                for (int c = 0; c < CLASS_NUM; c++) begin
                    if ((r_cnt[c] != '0) && (r_cnt[c] >= param_min_count)) begin
                        r_res_detect[c]                     <= 1'b1;
                        r_res_min_x[c*X_WIDTH +: X_WIDTH]   <= r_min_x[c];
                        r_res_max_x[c*X_WIDTH +: X_WIDTH]   <= r_max_x[c];
                        r_res_min_y[c*Y_WIDTH +: Y_WIDTH]   <= r_min_y[c];
                        r_res_max_y[c*Y_WIDTH +: Y_WIDTH]   <= r_max_y[c];
                    end else begin
                        r_res_detect[c]                     <= 1'b0;
                        r_res_min_x[c*X_WIDTH +: X_WIDTH]   <= '0;
                        r_res_max_x[c*X_WIDTH +: X_WIDTH]   <= '0;
                        r_res_min_y[c*Y_WIDTH +: Y_WIDTH]   <= '0;
                        r_res_max_y[c*Y_WIDTH +: Y_WIDTH]   <= '0;
                    end
                    r_res_count[c*COUNT_WIDTH +: COUNT_WIDTH] <= r_cnt[c];
                end
            end
        end
    end

    assign m_result_valid  = r_res_valid;
    assign m_result_detect = r_res_detect;
    assign m_result_min_x  = r_res_min_x;
    assign m_result_max_x  = r_res_max_x;
    assign m_result_min_y  = r_res_min_y;
    assign m_result_max_y  = r_res_max_y;
    assign m_result_count  = r_res_count;
    assign m_frame_error   = r_frame_error;

endmodule

// File: tb/tb_video_mnist_cnn_detection_bbox.sv
// Directed bench: default-width instance plus a COUNT_WIDTH=4 instance fed the same stream.
module tb_video_mnist_cnn_detection_bbox;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [8:0]   param_y_num = 9'd4;
    logic [15:0]  pmc = 16'd1;
    logic [3:0]   pmc4 = 4'd1;
    logic         tuser = 1'b0;
    logic         tlast = 1'b0;
    logic [9:0]   tdata = '0;
    logic         tvalid = 1'b0;
    logic         gaps = 1'b0;

    logic         res_valid, ferr;
    logic [9:0]   res_detect;
    logic [99:0]  min_x, max_x;
    logic [89:0]  min_y, max_y;
    logic [159:0] count;

    logic         res_valid4, ferr4;
    logic [9:0]   res_detect4;
    logic [99:0]  min_x4, max_x4;
    logic [89:0]  min_y4, max_y4;
    logic [39:0]  count4;

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    int ecount = 0;
    int hit_x[$];
    int hit_y[$];
    int hit_c[$];
    logic [9:0]   snap_det[$];
    logic [159:0] snap_cnt[$];

    always #5 aclk = ~aclk;

    video_mnist_cnn_detection_bbox_if #(.TUSER_WIDTH(1), .CLASS_NUM(10)) bus_a ();
    video_mnist_cnn_detection_bbox_if #(.TUSER_WIDTH(1), .CLASS_NUM(10)) bus_b ();

    assign bus_a.tuser  = tuser;
    assign bus_a.tlast  = tlast;
    assign bus_a.tdata  = tdata;
    assign bus_a.tvalid = tvalid;
    assign bus_b.tuser  = tuser;
    assign bus_b.tlast  = tlast;
    assign bus_b.tdata  = tdata;
    assign bus_b.tvalid = tvalid;

    video_mnist_cnn_detection_bbox dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .param_y_num     (param_y_num),
        .param_min_count (pmc),
        .s_axi4s         (bus_a),
        .m_result_valid  (res_valid),
        .m_result_detect (res_detect),
        .m_result_min_x  (min_x),
        .m_result_max_x  (max_x),
        .m_result_min_y  (min_y),
        .m_result_max_y  (max_y),
        .m_result_count  (count),
        .m_frame_error   (ferr)
    );

    video_mnist_cnn_detection_bbox #(.COUNT_WIDTH(4)) dut4 (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .param_y_num     (param_y_num),
        .param_min_count (pmc4),
        .s_axi4s         (bus_b),
        .m_result_valid  (res_valid4),
        .m_result_detect (res_detect4),
        .m_result_min_x  (min_x4),
        .m_result_max_x  (max_x4),
        .m_result_min_y  (min_y4),
        .m_result_max_y  (max_y4),
        .m_result_count  (count4),
        .m_frame_error   (ferr4)
    );

    // Strobe monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (res_valid === 1'b1) begin
            vcount = vcount + 1;
            snap_det.push_back(res_detect);
            snap_cnt.push_back(count);
        end
        if (ferr === 1'b1) ecount = ecount + 1;
    end

    function automatic logic [9:0] pix_data(input int x, input int y);
        logic [9:0] d = '0;
        for (int i = 0; i < hit_x.size(); i++)
            if (hit_x[i] == x && hit_y[i] == y) d[hit_c[i]] = 1'b1;
        return d;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic sof, input logic last, input logic [9:0] data);
        int n;
        n = gaps ? $urandom_range(0, 2) : 0;
        repeat (n) step();
        tuser  = sof;
        tlast  = last;
        tdata  = data;
        tvalid = 1'b1;
        step();
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
    endtask

    // Pixels [first, stop) of a w x h frame; pixel 0 carries SOF.
    task automatic send_frame(input int w, input int h, input int first, input int stop);
        for (int p = first; p < stop && p < w * h; p++)
            beat(p == 0, (p % w) == w - 1, pix_data(p % w, p / w));
    endtask

    task automatic clear_hits();
        hit_x.delete();
        hit_y.delete();
        hit_c.delete();
    endtask

    task automatic add_hit(input int x, input int y, input int c);
        hit_x.push_back(x);
        hit_y.push_back(y);
        hit_c.push_back(c);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #2;
        checks++; if (bus_a.tready !== 1'b0) begin errors++;
            $display("FAIL reset_tready: got %b want 0", bus_a.tready); end
        checks++; if (res_valid !== 1'b0 || ferr !== 1'b0) begin errors++;
            $display("FAIL reset_strobes: valid %b ferr %b want 0 0", res_valid, ferr); end
        checks++; if (res_detect !== '0 || count !== '0 || min_x !== '0 || max_y !== '0) begin
            errors++;
            $display("FAIL reset_results: detect %h count %h min_x %h max_y %h want 0",
                     res_detect, count, min_x, max_y); end
        aresetn = 1'b1;
        #1;
        checks++; if (bus_a.tready !== 1'b0) begin errors++;
            $display("FAIL release_tready_early: got %b want 0", bus_a.tready); end
        step();
        checks++; if (bus_a.tready !== 1'b1) begin errors++;
            $display("FAIL release_tready: got %b want 1", bus_a.tready); end
    endtask

    task automatic test_basic_frame();
        clear_hits();
        add_hit(2, 1, 3); add_hit(5, 2, 3); add_hit(3, 3, 3);
        pmc = 16'd1;
        send_frame(8, 4, 0, 32);
        checks++; if (res_valid !== 1'b0) begin errors++;
            $display("FAIL basic_valid_early: got %b want 0", res_valid); end
        step();
        checks++; if (res_valid !== 1'b1) begin errors++;
            $display("FAIL basic_valid: got %b want 1", res_valid); end
        checks++; if (res_detect !== 10'h008) begin errors++;
            $display("FAIL basic_detect: got %h want 008", res_detect); end
        checks++; if (min_x !== (100'd2 << 30) || max_x !== (100'd5 << 30)) begin errors++;
            $display("FAIL basic_x: min %h max %h want %h %h", min_x, max_x,
                     100'd2 << 30, 100'd5 << 30); end
        checks++; if (min_y !== (90'd1 << 27) || max_y !== (90'd3 << 27)) begin errors++;
            $display("FAIL basic_y: min %h max %h want %h %h", min_y, max_y,
                     90'd1 << 27, 90'd3 << 27); end
        checks++; if (count !== (160'd3 << 48)) begin errors++;
            $display("FAIL basic_count: got %h want %h", count, 160'd3 << 48); end
        step();
        checks++; if (res_valid !== 1'b0) begin errors++;
            $display("FAIL basic_valid_pulse: got %b want 0", res_valid); end
        checks++; if (res_detect !== 10'h008) begin errors++;
            $display("FAIL basic_hold: got %h want 008", res_detect); end
    endtask

    task automatic test_min_count();
        pmc = 16'd4;
        send_frame(8, 4, 0, 32);
        step();
        checks++; if (res_valid !== 1'b1 || res_detect !== 10'h000) begin errors++;
            $display("FAIL mincount_detect: valid %b detect %h want 1 000", res_valid,
                     res_detect); end
        checks++; if (count !== (160'd3 << 48)) begin errors++;
            $display("FAIL mincount_count: got %h want %h", count, 160'd3 << 48); end
        checks++; if (min_x !== '0 || max_x !== '0 || min_y !== '0 || max_y !== '0) begin
            errors++;
            $display("FAIL mincount_bounds: %h %h %h %h want 0", min_x, max_x, min_y, max_y);
        end
        pmc = 16'd1;
        step();
    endtask

    task automatic test_early_sof();
        int v0, e0;
        v0 = vcount;
        e0 = ecount;
        clear_hits();
        add_hit(1, 1, 5); add_hit(2, 0, 5);
        send_frame(8, 4, 0, 20);
        clear_hits();
        add_hit(0, 0, 7); add_hit(6, 3, 7);
        beat(1'b1, 1'b0, pix_data(0, 0));
        checks++; if (ferr !== 1'b1) begin errors++;
            $display("FAIL sof_error: got %b want 1", ferr); end
        step();
        checks++; if (ferr !== 1'b0) begin errors++;
            $display("FAIL sof_error_pulse: got %b want 0", ferr); end
        checks++; if (vcount !== v0) begin errors++;
            $display("FAIL sof_no_valid: pulses %0d want %0d", vcount, v0); end
        send_frame(8, 4, 1, 32);
        step();
        checks++; if (res_valid !== 1'b1 || res_detect !== 10'h080) begin errors++;
            $display("FAIL sof_detect: valid %b detect %h want 1 080", res_valid, res_detect);
        end
        checks++; if (count !== (160'd2 << 112)) begin errors++;
            $display("FAIL sof_count: got %h want %h", count, 160'd2 << 112); end
        checks++; if (min_x !== '0 || max_x !== (100'd6 << 70) || min_y !== '0 ||
                      max_y !== (90'd3 << 63)) begin errors++;
            $display("FAIL sof_bounds: %h %h %h %h", min_x, max_x, min_y, max_y); end
        step();
        checks++; if (vcount !== v0 + 1 || ecount !== e0 + 1) begin errors++;
            $display("FAIL sof_pulse_counts: valid %0d err %0d want %0d %0d", vcount, ecount,
                     v0 + 1, e0 + 1); end
    endtask

    task automatic test_pre_sof_discard();
        clear_hits();
        for (int i = 0; i < 5; i++) beat(1'b0, i == 2, 10'h3ff);
        send_frame(8, 4, 0, 32);
        step();
        checks++; if (res_valid !== 1'b1 || res_detect !== 10'h000) begin errors++;
            $display("FAIL presof_detect: valid %b detect %h want 1 000", res_valid,
                     res_detect); end
        checks++; if (count !== '0 || max_x !== '0 || max_y !== '0) begin errors++;
            $display("FAIL presof_results: count %h max_x %h max_y %h want 0", count, max_x,
                     max_y); end
        step();
    endtask

    task automatic test_one_row_frame();
        param_y_num = 9'd1;
        clear_hits();
        beat(1'b1, 1'b1, 10'h200);
        param_y_num = 9'd4;
        checks++; if (res_valid !== 1'b0) begin errors++;
            $display("FAIL onerow_valid_early: got %b want 0", res_valid); end
        step();
        checks++; if (res_valid !== 1'b1 || res_detect !== 10'h200) begin errors++;
            $display("FAIL onerow_detect: valid %b detect %h want 1 200", res_valid,
                     res_detect); end
        checks++; if (count !== (160'd1 << 144)) begin errors++;
            $display("FAIL onerow_count: got %h want %h", count, 160'd1 << 144); end
        step();
    endtask

    task automatic test_saturation();
        clear_hits();
        for (int p = 0; p < 20; p++) add_hit(p % 8, p / 8, 0);
        for (int pass = 0; pass < 2; pass++) begin
            gaps = (pass == 1);
            send_frame(8, 4, 0, 32);
            repeat (2) step();
            checks++; if (count4[3:0] !== 4'd15 || res_detect4[0] !== 1'b1) begin errors++;
                $display("FAIL sat_count4 pass %0d: count %0d detect %b want 15 1", pass,
                         count4[3:0], res_detect4[0]); end
            checks++; if (count[15:0] !== 16'd20 || res_detect !== 10'h001) begin errors++;
                $display("FAIL sat_count16 pass %0d: count %0d detect %h want 20 001", pass,
                         count[15:0], res_detect); end
            checks++; if (min_x4[9:0] !== 10'd0 || max_x4[9:0] !== 10'd7 ||
                          min_y4[8:0] !== 9'd0 || max_y4[8:0] !== 9'd2) begin errors++;
                $display("FAIL sat_bounds pass %0d: %0d %0d %0d %0d want 0 7 0 2", pass,
                         min_x4[9:0], max_x4[9:0], min_y4[8:0], max_y4[8:0]); end
        end
        gaps = 1'b0;
    endtask

    task automatic test_back_to_back();
        snap_det.delete();
        snap_cnt.delete();
        clear_hits();
        add_hit(0, 0, 1);
        send_frame(8, 4, 0, 32);
        clear_hits();
        add_hit(7, 3, 2);
        send_frame(8, 4, 0, 32);
        repeat (3) step();
        checks++; if (snap_det.size() !== 2) begin errors++;
            $display("FAIL b2b_pulses: got %0d want 2", snap_det.size()); end
        else begin
            checks++; if (snap_det[0] !== 10'h002 || snap_cnt[0] !== (160'd1 << 16)) begin
                errors++;
                $display("FAIL b2b_first: detect %h count %h want 002 %h", snap_det[0],
                         snap_cnt[0], 160'd1 << 16); end
            checks++; if (snap_det[1] !== 10'h004 || snap_cnt[1] !== (160'd1 << 32)) begin
                errors++;
                $display("FAIL b2b_second: detect %h count %h want 004 %h", snap_det[1],
                         snap_cnt[1], 160'd1 << 32); end
        end
        checks++; if (min_x !== (100'd7 << 20) || max_y !== (90'd3 << 18)) begin errors++;
            $display("FAIL b2b_bounds: min_x %h max_y %h want %h %h", min_x, max_y,
                     100'd7 << 20, 90'd3 << 18); end
    endtask

    task automatic test_mid_frame_reset();
        int v0;
        clear_hits();
        add_hit(1, 0, 4);
        send_frame(8, 4, 0, 10);
        aresetn = 1'b0;
        #1;
        checks++; if (bus_a.tready !== 1'b0 || res_detect !== '0 || count !== '0) begin
            errors++;
            $display("FAIL midreset_clear: tready %b detect %h count %h want 0",
                     bus_a.tready, res_detect, count); end
        step();
        aresetn = 1'b1;
        v0 = vcount;
        send_frame(8, 4, 10, 32);
        repeat (3) step();
        checks++; if (vcount !== v0) begin errors++;
            $display("FAIL midreset_no_valid: pulses %0d want %0d", vcount, v0); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_min_count();
        test_early_sof();
        test_pre_sof_discard();
        test_one_row_frame();
        test_saturation();
        test_back_to_back();
        test_mid_frame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_mnist_cnn_detection_bbox.md
# video_mnist_cnn_detection_bbox

Sink stage directly downstream of the MNIST CNN detection core. Consumes the core's per-pixel class-hit map as AXI4-Stream. For each digit class it accumulates a pixel count and a bounding box (min/max x, y) over one frame. At end of frame it latches the per-class results into output registers and pulses a result strobe for the overlay and readout logic.

## Interface
- TUSER_WIDTH, 1, stream tuser width; bit 0 is start-of-frame (SOF)
- CLASS_NUM, 10, number of class bits in tdata
- X_WIDTH, 10, x coordinate width (detection-map pixels)
- Y_WIDTH, 9, y coordinate width
- COUNT_WIDTH, 16, per-class pixel counter width
- aclk  input  1  clock
- aresetn  input  1  reset, asynchronous assert, active low
- param_y_num  input  Y_WIDTH  rows per frame (≥1), sampled at each frame start
- param_min_count  input  COUNT_WIDTH  minimum hits for a class to be reported, sampled at frame close
- s_axi4s_tuser  input  TUSER_WIDTH  bit 0 = SOF
- s_axi4s_tlast  input  1  end of row
- s_axi4s_tdata  input  CLASS_NUM  bit c = pixel classified as class c
- s_axi4s_tvalid  input  1  beat valid
- s_axi4s_tready  output  1  sink ready
- m_result_valid  output  1  one-cycle strobe, new results latched
- m_result_detect  output  CLASS_NUM  class reported
- m_result_min_x / m_result_max_x  output  CLASS_NUM*X_WIDTH  per-class x bounds, class c at [c*X_WIDTH +: X_WIDTH]
- m_result_min_y / m_result_max_y  output  CLASS_NUM*Y_WIDTH  per-class y bounds
- m_result_count  output  CLASS_NUM*COUNT_WIDTH  per-class hit count
- m_frame_error  output  1  one-cycle strobe, frame aborted by an early SOF

## Operation
- Beat accepted = tvalid && tready.
- tready: reset value 0; registered 1 from the first aclk edge after aresetn deasserts. No backpressure after that.
- State machine:
  - WAIT_SOF (reset state): accepted beats without SOF are discarded.
  - On an accepted SOF beat: go to ACTIVE; x=0, y=0; reload all accumulators; apply that beat.
  - ACTIVE: each accepted beat applies at (x, y), then x+1.
  - tlast in ACTIVE: x←0, y+1.
  - tlast with y == param_y_num−1: frame close, back to WAIT_SOF.
- Accumulator reload values: count=0, min_x/min_y all ones, max_x/max_y=0.
- Apply: for each c with tdata[c]=1 → min/max updated with x, y; count+1, saturating at 2^COUNT_WIDTH−1.
- x saturates at 2^X_WIDTH−1; y saturates at 2^Y_WIDTH−1. No wrap.
- SOF in ACTIVE with (x,y) ≠ (0,0):
  - Pulse m_frame_error; results are not latched.
  - Accumulators reload and the SOF beat is applied as pixel (0,0) of the new frame; stay in ACTIVE.
- SOF together with tlast on the same beat: SOF handling first, then the tlast rules. With param_y_num=1 this is a one-pixel-wide frame that closes immediately.
- Frame close:
  - detect[c] = (count_c ≠ 0) && (count_c ≥ param_min_count).
  - Detected class: bounds and count latched from the accumulators.
  - Undetected class: bounds latched as 0; count latched as-is.
- The closing beat's own hits are included in the latched results.
- Outputs hold until the next frame close.
- Reset values: all m_result_* = 0, m_frame_error = 0, state = WAIT_SOF.
- aresetn asserted mid-frame discards the frame with no strobe.

## Timing
- Accumulator update: registered, one cycle after the accepted beat.
- m_result_*: latched and m_result_valid high on the 2nd aclk edge after the closing beat is accepted (1 cycle to fold the last beat, 1 to latch). High for exactly 1 cycle.
- m_frame_error: high on the 1st edge after the offending SOF beat, for 1 cycle.
- Back-to-back frames: an SOF accepted in the cycle right after the closing beat is handled normally. The latch uses the snapshot of the closed frame and is not disturbed by the reload.
- tvalid gaps anywhere have no effect on coordinates.

## Test plan
- Reset release: tready 0 during reset, 1 one cycle after release; all outputs 0.
- Frame 8×4, param_y_num=4, class 3 hits at (2,1),(5,2),(3,3), param_min_count=1:
  - m_result_valid pulses 2 cycles after the last beat.
  - detect=0x008; class 3 min_x=2 max_x=5 min_y=1 max_y=3 count=3; other classes bounds 0, count 0.
- Same frame with param_min_count=4: detect=0, class 3 count=3, class 3 bounds 0.
- SOF injected at (4,2) of a 4-row frame: m_frame_error pulse, no m_result_valid. The following full frame reports only its own hits.
- Beats before the first SOF carrying all class bits set, then a clean frame with no hits: detect=0, all counts 0.
- COUNT_WIDTH=4, 20 class-0 hits in one frame: count=15 (saturated), detect[0]=1. Random tvalid gaps give identical results.
